// File: rtl/adc_spi_pkg.sv
// Shared constants and types for the ADC-side SPI responder.
// Frame geometry, register-file size and the frame FSM states.
package adc_spi_pkg;

  localparam int FRAME_BITS      = 16;
  localparam int DATA_BITS       = 12;
  localparam int LEAD_ZEROS      = 4;
  localparam int ADDR_FIRST_EDGE = 3;
  localparam int ADDR_BITS       = 3;
  localparam int NUM_CHNL        = 8;
  localparam int CNT_W           = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    WAIT_HI,
    IDLE,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// 3-FF synchronizer for an asynchronous SPI pin.
// Ports: clk, rst_n, pin_i -> sync_o (level), rise_o, fall_o (1-clk pulses).
module spi_pin_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
    end else begin
      sh_q <= {sh_q[1:0], pin_i};
    end
  end

  // sh_q[2] is the previous synced level, used only for edge detection.
  assign sync_o = sh_q[1];
  assign rise_o = sh_q[1] & ~sh_q[2];
  assign fall_o = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/adc_spi_responder.sv
// SPI mode-0 responder standing in for the ADC: returns 12-bit samples.
// Ports: clk/rst_n, SCLK/SS_n/MOSI/MISO, wr_* loader, frame_* status.
module adc_spi_responder
  import adc_spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SCLK,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  input  logic       wr_en,
  input  logic [2:0] wr_chnl,
  input  logic [11:0] wr_data,
  output logic       frame_done,
  output logic [2:0] frame_chnl,
  output logic [2:0] next_chnl
);

  logic sclk_lvl_unused;
  logic sclk_rise;
  logic sclk_fall;
  logic ss_lvl;
  logic ss_rise;
  logic ss_fall;

  spi_pin_sync u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_i  (SCLK),
    .sync_o (sclk_lvl_unused),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_pin_sync u_ss_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_i  (SS_n),
    .sync_o (ss_lvl),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  // Two stages keep MOSI aligned with the synced SCLK edge.
  logic [1:0] mosi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_q <= '0;
    end else begin
      mosi_q <= {mosi_q[0], MOSI};
    end
  end

  logic mosi_s;
  assign mosi_s = mosi_q[1];

  logic [DATA_BITS-1:0] rf_q [NUM_CHNL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHNL; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wr_en) begin
      rf_q[wr_chnl] <= wr_data;
    end
  end

  state_e                state_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [ADDR_BITS-1:0]  rx_addr_q;
  logic [FRAME_BITS-1:0] tx_shift_q;
  logic                  miso_q;
  logic                  done_q;
  logic [2:0]            frame_chnl_q;
  logic [2:0]            next_chnl_q;

  // Address bits arrive on rises ADDR_FIRST_EDGE.. (count is pre-increment).
  localparam logic [CNT_W-1:0] ADDR_LO = CNT_W'(ADDR_FIRST_EDGE - 1);
  localparam logic [CNT_W-1:0] ADDR_HI =
    CNT_W'(ADDR_FIRST_EDGE + ADDR_BITS - 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

  logic addr_win;
  assign addr_win = (bit_cnt_q >= ADDR_LO) && (bit_cnt_q <= ADDR_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_HI;
      bit_cnt_q    <= '0;
      rx_addr_q    <= '0;
      tx_shift_q   <= '0;
      miso_q       <= 1'b0;
      done_q       <= 1'b0;
      frame_chnl_q <= '0;
      next_chnl_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        WAIT_HI: begin
          miso_q <= 1'b0;
          if (ss_lvl) state_q <= IDLE;
        end
        IDLE: begin
          miso_q <= 1'b0;
          if (ss_fall) begin
            // Snapshot reads the pre-write value on a same-clk write.
            tx_shift_q <= {{LEAD_ZEROS{1'b0}}, rf_q[next_chnl_q]};
            bit_cnt_q  <= '0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            miso_q  <= 1'b0;
            state_q <= IDLE;
          end else if (sclk_rise) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (addr_win) begin
              rx_addr_q <= {rx_addr_q[ADDR_BITS-2:0], mosi_s};
            end
            if (bit_cnt_q == LAST_CNT) begin
              frame_chnl_q <= next_chnl_q;
              next_chnl_q  <= rx_addr_q;
              done_q       <= 1'b1;
              miso_q       <= 1'b0;
              state_q      <= DONE;
            end
          end else if (sclk_fall && bit_cnt_q != '0) begin
            // MISO mirrors the new MSB after the shift.
            tx_shift_q <= tx_shift_q << 1;
            miso_q     <= tx_shift_q[FRAME_BITS-2];
          end
        end
        DONE: begin
          miso_q <= 1'b0;
          if (ss_rise) state_q <= IDLE;
        end
        default: state_q <= WAIT_HI;
      endcase
    end
  end

  assign MISO       = miso_q;
  assign frame_done = done_q;
  assign frame_chnl = frame_chnl_q;
  assign next_chnl  = next_chnl_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: SPI master model plus
// hand-computed frame expectations.
module tb_adc_spi_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SCLK;
  logic        SS_n;
  logic        MOSI;
  logic        MISO;
  logic        wr_en;
  logic [2:0]  wr_chnl;
  logic [11:0] wr_data;
  logic        frame_done;
  logic [2:0]  frame_chnl;
  logic [2:0]  next_chnl;

  int errs   = 0;
  int checks = 0;
  int fd_cnt = 0;

  logic [11:0] rf_m [8];

  adc_spi_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .SCLK       (SCLK),
    .SS_n       (SS_n),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .wr_en      (wr_en),
    .wr_chnl    (wr_chnl),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .frame_chnl (frame_chnl),
    .next_chnl  (next_chnl)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
  end

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] ch, input logic [11:0] d);
    @(negedge clk);
    wr_chnl = ch;
    wr_data = d;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
    rf_m[ch] = d;
  endtask

  // Mode-0 master: MISO sampled at each SCLK rise. Optional write is
  // timed to the clk that acts on the synced SS_n fall (ph must be 0).
  task automatic frame(input logic [15:0] mo, input int nsclk,
                       input int half, input int ph, input bit dowr,
                       input logic [2:0] wch, input logic [11:0] wd,
                       output logic [15:0] mi, output logic ex);
    mi = '0;
    ex = 1'b0;
    @(negedge clk);
    #ph;
    SS_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (dowr) begin
      wr_chnl = wch;
      wr_data = wd;
      wr_en   = 1'b1;
    end
    @(negedge clk);
    wr_en = 1'b0;
    if (dowr) rf_m[wch] = wd;
    repeat (3) @(negedge clk);
    #ph;
    for (int i = 0; i < nsclk; i++) begin
      MOSI = (i < 16) ? mo[15-i] : 1'b0;
      repeat (half) @(negedge clk);
      #ph;
      SCLK = 1'b1;
      if (i < 16) mi = {mi[14:0], MISO};
      else ex = ex | MISO;
      repeat (half) @(negedge clk);
      #ph;
      SCLK = 1'b0;
    end
    repeat (half) @(negedge clk);
    #ph;
    SS_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  logic [15:0] mi;
  logic        ex;
  int          fd0;
  int          nm;
  logic [15:0] w;
  int adds [7] = '{0, 1, 2, 3, 4, 7, 0};
  int phs  [7] = '{1, 2, 4, 6, 8, 9, 3};

  initial begin
    rst_n   = 1'b0;
    SCLK    = 1'b0;
    SS_n    = 1'b1;
    MOSI    = 1'b0;
    wr_en   = 1'b0;
    wr_chnl = '0;
    wr_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_miso", 16'(MISO), 16'h0);
    chk("rst_done", 16'(frame_done), 16'h0);
    chk("rst_fchnl", 16'(frame_chnl), 16'h0);
    chk("rst_nchnl", 16'(next_chnl), 16'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int k = 0; k < 8; k++) wr(3'(k), 12'h100 + 12'(k));

    // ADD=3: returns ch0
    fd0 = fd_cnt;
    frame(16'h1800, 16, 4, 0, 1'b0, 3'd0, 12'h0, mi, ex);
    chk("f1_miso", mi, 16'h0100);
    chk("f1_fchnl", 16'(frame_chnl), 16'h0);
    chk("f1_nchnl", 16'(next_chnl), 16'h3);
    chk("f1_done", 16'(fd_cnt - fd0), 16'h1);

    // ADD=5: returns ch3
    frame(16'h2800, 16, 4, 0, 1'b0, 3'd0, 12'h0, mi, ex);
    chk("f2_miso", mi, 16'h0103);
    chk("f2_fchnl", 16'(frame_chnl), 16'h3);
    chk("f2_nchnl", 16'(next_chnl), 16'h5);

    // write ch5 in the snapshot clk: old value goes out
    frame(16'h2800, 16, 4, 0, 1'b1, 3'd5, 12'hABC, mi, ex);
    chk("f3_old", mi, 16'h0105);
    chk("f3_nchnl", 16'(next_chnl), 16'h5);

    frame(16'h2800, 16, 4, 0, 1'b0, 3'd0, 12'h0, mi, ex);
    chk("f4_new", mi, 16'h0ABC);
    chk("f4_fchnl", 16'(frame_chnl), 16'h5);

    // abort after 8 SCLK
    fd0 = fd_cnt;
    frame(16'h1000, 8, 4, 0, 1'b0, 3'd0, 12'h0, mi, ex);
    chk("ab_done", 16'(fd_cnt - fd0), 16'h0);
    chk("ab_nchnl", 16'(next_chnl), 16'h5);
    chk("ab_fchnl", 16'(frame_chnl), 16'h5);

    frame(16'h0000, 16, 4, 0, 1'b0, 3'd0, 12'h0, mi, ex);
    chk("ab_next_miso", mi, 16'h0ABC);
    chk("ab_next_nchnl", 16'(next_chnl), 16'h0);

    // 20 SCLK in one frame
    fd0 = fd_cnt;
    frame(16'h0800, 20, 4, 0, 1'b0, 3'd0, 12'h0, mi, ex);
    chk("x20_miso", mi, 16'h0100);
    chk("x20_extra", 16'(ex), 16'h0);
    chk("x20_done", 16'(fd_cnt - fd0), 16'h1);
    chk("x20_nchnl", 16'(next_chnl), 16'h1);

    // pot channels at slowest SCLK with drifting phase
    nm = 1;
    for (int i = 0; i < 7; i++) begin
      w = 16'(adds[i]) << 11;
      frame(w, 16, 4, phs[i], 1'b0, 3'd0, 12'h0, mi, ex);
      chk($sformatf("sw%0d_miso", i), mi, {4'h0, rf_m[nm]});
      nm = adds[i];
      chk($sformatf("sw%0d_nchnl", i), 16'(next_chnl), 16'(nm));
    end

    // reset mid-frame, released with SS_n still low
    @(negedge clk);
    SS_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      MOSI = 1'b1;
      repeat (4) @(negedge clk);
      SCLK = 1'b1;
      repeat (4) @(negedge clk);
      SCLK = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("mr_nchnl", 16'(next_chnl), 16'h0);
    chk("mr_fchnl", 16'(frame_chnl), 16'h0);
    fd0 = fd_cnt;
    for (int i = 0; i < 6; i++) begin
      repeat (4) @(negedge clk);
      SCLK = 1'b1;
      repeat (3) @(negedge clk);
      chk($sformatf("mr_miso%0d", i), 16'(MISO), 16'h0);
      @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (4) @(negedge clk);
    chk("mr_done", 16'(fd_cnt - fd0), 16'h0);
    SS_n = 1'b1;
    MOSI = 1'b0;
    repeat (6) @(negedge clk);
    frame(16'h1000, 16, 4, 0, 1'b0, 3'd0, 12'h0, mi, ex);
    chk("mr_f_miso", mi, 16'h0000);
    chk("mr_f_fchnl", 16'(frame_chnl), 16'h0);
    chk("mr_f_nchnl", 16'(next_chnl), 16'h2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
